// File: rtl/an_sec_decode_ctrl.sv
// Bit-serial single-error-correcting decoder controller for the AN product code.
// It reduces the codeword mod A, corrects one +/-2^(k-1) error using an external LUT, and divides by A.
module an_sec_decode_ctrl #(
    parameter int A  = 18613,
    parameter int CW = 45,
    parameter int DW = 30,
    parameter int RW = 15,
    parameter int LW = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        in_code,
    output logic [RW-1:0]        lut_r,
    input  logic signed [LW-1:0] lut_l,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic signed [LW-1:0] out_loc,
    output logic                 out_corr,
    output logic                 out_uncorr
);

    // Wide enough to hold a 2^(k-1) correction for any |k| the signed location can express.
    localparam int WW = (1 << (LW - 1)) + 2;
    localparam logic [RW:0] AV = (RW + 1)'(A);

    typedef enum logic [2:0] {IDLE, MOD, LOOK, CORR, DIV, DONE} state_t;

    state_t state, state_nx;

    logic [CW-1:0]        word;
    logic [RW-1:0]        rem;
    logic [5:0]           cnt;
    logic [DW-1:0]        quo;
    logic signed [LW-1:0] lreg;
    logic signed [LW-1:0] loc;
    logic                 corr;
    logic                 uncorr;

    logic                 cur_bit;
    logic [RW:0]          trial;
    logic                 ge;
    logic [RW-1:0]        rem_nx;
    logic                 last;
    logic [LW-1:0]        kmag;
    logic [WW-1:0]        wide;
    logic [WW-1:0]        delta;
    logic [WW-1:0]        sum;
    logic                 bad;
    logic [DW:0]          qfin;

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid)              state_nx = MOD;
            MOD:  if (last)                  state_nx = LOOK;
            LOOK:                            state_nx = CORR;
            CORR:                            state_nx = DIV;
            DIV:  if (last)                  state_nx = DONE;
            DONE: if (out_valid && out_ready) state_nx = IDLE;
            default:                         state_nx = IDLE;
        endcase
    end

    // One shift-and-subtract step, shared by the mod-A reduction and the restoring division.
    always_comb begin
        cur_bit = word[6'(CW - 1) - cnt];
        trial   = {rem, cur_bit};
        ge      = (trial >= AV);
        rem_nx  = ge ? RW'(trial - AV) : RW'(trial);
        last    = (cnt == 6'(CW - 1));
        qfin    = {quo, ge};
    end

    // A positive location means the error added 2^(k-1), so it is subtracted back, and vice versa.
    always_comb begin
        kmag  = lreg[LW-1] ? -lreg : lreg;
        wide  = WW'(word);
        delta = WW'(1) << (kmag - LW'(1));
        sum   = lreg[LW-1] ? (wide + delta) : (wide - delta);
        bad   = lreg[LW-1] ? ((sum >> CW) != '0) : (delta > wide);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word       <= '0;
            rem        <= '0;
            cnt        <= '0;
            quo        <= '0;
            lreg       <= '0;
            loc        <= '0;
            corr       <= 1'b0;
            uncorr     <= 1'b0;
            lut_r      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_loc    <= '0;
            out_corr   <= 1'b0;
            out_uncorr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word   <= in_code;
                        rem    <= '0;
                        cnt    <= '0;
                        corr   <= 1'b0;
                        uncorr <= 1'b0;
                        loc    <= '0;
                    end
                end
                MOD: begin
                    rem <= rem_nx;
                    cnt <= cnt + 6'd1;
                    if (last) lut_r <= rem_nx;
                end
                LOOK: lreg <= lut_l;
                CORR: begin
                    if (rem != '0) begin
                        if (lreg == '0 || bad) begin
                            uncorr <= 1'b1;
                        end else begin
                            word <= sum[CW-1:0];
                            corr <= 1'b1;
                            loc  <= lreg;
                        end
                    end
                    rem <= '0;
                    cnt <= '0;
                    quo <= '0;
                end
                DIV: begin
                    rem <= rem_nx;
                    cnt <= cnt + 6'd1;
                    quo <= qfin[DW-1:0];
                    if (last) begin
                        out_data   <= qfin[DW-1:0];
                        out_loc    <= loc;
                        out_corr   <= corr & ~qfin[DW];
                        out_uncorr <= uncorr | qfin[DW];
                    end
                end
                DONE: begin
                    if (!out_valid)     out_valid <= 1'b1;
                    else if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_an_sec_decode_ctrl.sv
// Self-checking bench for an_sec_decode_ctrl: directed spec vectors, randomized words,
// backpressure and mid-operation reset, all checked against an arithmetic reference model.
module tb_an_sec_decode_ctrl;

    localparam longint A   = 18613;
    localparam int     LAT = 93;

    typedef struct packed {
        logic [14:0]        r;
        logic [29:0]        data;
        logic signed [6:0]  loc;
        logic               corr;
        logic               uncorr;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [44:0]       in_code = '0;
    logic [14:0]       lut_r;
    logic signed [6:0] lut_l;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [29:0]       out_data;
    logic signed [6:0] out_loc;
    logic              out_corr;
    logic              out_uncorr;

    int n_cmp = 0;
    int n_fail = 0;

    an_sec_decode_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .lut_r(lut_r), .lut_l(lut_l),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_loc(out_loc), .out_corr(out_corr), .out_uncorr(out_uncorr)
    );

    always #5 clk = ~clk;

    // The SEC LUT: smallest k with 2^(k-1) == r (mod A) gives +k, with -2^(k-1) == r gives -k.
    function automatic logic signed [6:0] lut_fn(input logic [14:0] r);
        longint p;
        lut_fn = '0;
        if (r != 0) begin
            for (int k = 45; k >= 1; k--) begin
                p = (longint'(1) << (k - 1)) % A;
                if (p == longint'(r))                 lut_fn = 7'(k);
                else if ((A - p) % A == longint'(r))  lut_fn = 7'(-k);
            end
        end
    endfunction

    always_comb lut_l = lut_fn(lut_r);

    function automatic res_t model(input longint code);
        res_t   e;
        longint r, w, nw, q, d;
        int     k, l;
        bit     applied;
        r = code % A;
        w = code;
        applied = 0;
        e = '0;
        e.r = 15'(r);
        l = 0;
        if (r != 0) begin
            l = int'(lut_fn(15'(r)));
            if (l == 0) begin
                e.uncorr = 1;
            end else begin
                k  = (l < 0) ? -l : l;
                d  = longint'(1) << (k - 1);
                nw = (l > 0) ? code - d : code + d;
                if (nw < 0 || nw >= (longint'(1) << 45)) e.uncorr = 1;
                else begin
                    w = nw;
                    applied = 1;
                end
            end
        end
        q = w / A;
        if (q >= (longint'(1) << 30)) e.uncorr = 1;
        e.data = 30'(q);
        e.loc  = applied ? 7'(l) : 7'sd0;
        e.corr = applied && (q < (longint'(1) << 30));
        return e;
    endfunction

    function automatic longint rand_code();
        longint data, c;
        int     j;
        data = longint'($urandom) & ((longint'(1) << 30) - 1);
        c    = data * A;
        j    = int'($urandom_range(0, 44));
        case ($urandom_range(0, 3))
            0: ;
            1: c = c + (longint'(1) << j);
            2: c = c - (longint'(1) << j);
            default: c = {longint'($urandom), 32'($urandom)};
        endcase
        if (c < 0 || c >= (longint'(1) << 45)) c = c & ((longint'(1) << 45) - 1);
        return c;
    endfunction

    task automatic send_word(input longint code, output res_t obs, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 45'(code);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_code  = 45'({$urandom, $urandom});
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        obs = '{r: lut_r, data: out_data, loc: out_loc, corr: out_corr, uncorr: out_uncorr};
    endtask

    task automatic release_word();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || lut_r !== '0 || out_data !== '0 ||
            out_loc !== '0 || out_corr !== 1'b0 || out_uncorr !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset: in_ready=%b out_valid=%b lut_r=%0d data=%0d loc=%0d corr=%b uncorr=%b, need 1 0 0 0 0 0 0",
                     in_ready, out_valid, lut_r, out_data, out_loc, out_corr, out_uncorr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        longint codes[6];
        res_t   obs, exp;
        int     lat;
        codes[0] = A;
        codes[1] = A + 4;
        codes[2] = A * 1000 - 8192;
        codes[3] = 3;
        codes[4] = (longint'(1) << 30) * A;
        codes[5] = (longint'(1) << 45) - 1;
        foreach (codes[i]) begin
            exp = model(codes[i]);
            send_word(codes[i], obs, lat);
            n_cmp++;
            if (obs !== exp || lat != LAT) begin
                n_fail++;
                $display("[TB] FAIL directed[%0d]: got r=%0d data=%0d loc=%0d corr=%b unc=%b lat=%0d, need r=%0d data=%0d loc=%0d corr=%b unc=%b lat=%0d",
                         i, obs.r, obs.data, obs.loc, obs.corr, obs.uncorr, lat,
                         exp.r, exp.data, exp.loc, exp.corr, exp.uncorr, LAT);
            end
            release_word();
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL directed[%0d] handshake: in_ready=%b out_valid=%b, need 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random();
        longint c;
        res_t   obs, exp;
        int     lat;
        for (int n = 0; n < 24; n++) begin
            c   = rand_code();
            exp = model(c);
            send_word(c, obs, lat);
            n_cmp++;
            if (obs !== exp || lat != LAT || (obs.corr && obs.uncorr)) begin
                n_fail++;
                $display("[TB] FAIL random[%0d] code=%0d: got data=%0d loc=%0d corr=%b unc=%b lat=%0d, need data=%0d loc=%0d corr=%b unc=%b lat=%0d",
                         n, c, obs.data, obs.loc, obs.corr, obs.uncorr, lat,
                         exp.data, exp.loc, exp.corr, exp.uncorr, LAT);
            end
            release_word();
        end
    endtask

    task automatic test_backpressure();
        res_t   obs, exp, now;
        int     lat;
        longint c;
        c   = A * 777 + 32;
        exp = model(c);
        send_word(c, obs, lat);
        n_cmp++;
        if (obs !== exp || lat != LAT) begin
            n_fail++;
            $display("[TB] FAIL backpressure word: got data=%0d loc=%0d lat=%0d, need data=%0d loc=%0d lat=%0d",
                     obs.data, obs.loc, lat, exp.data, exp.loc, LAT);
        end
        in_valid = 1'b1;
        in_code  = 45'(A * 5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            now = '{r: lut_r, data: out_data, loc: out_loc, corr: out_corr, uncorr: out_uncorr};
            n_cmp++;
            if (now !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL backpressure hold[%0d]: data=%0d loc=%0d out_valid=%b in_ready=%b, need data=%0d loc=%0d 1 0",
                         i, now.data, now.loc, out_valid, in_ready, exp.data, exp.loc);
            end
        end
        in_valid = 1'b0;
        release_word();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL backpressure release: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_div();
        res_t   obs, exp;
        int     lat;
        longint c;
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 45'(A * 12345 - 64);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset mid-DIV: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL aborted word presented: out_valid=%b, need 0", out_valid);
                break;
            end
        end
        c   = A * 4242 - 1024;
        exp = model(c);
        send_word(c, obs, lat);
        n_cmp++;
        if (obs !== exp || lat != LAT) begin
            n_fail++;
            $display("[TB] FAIL after reset: got data=%0d loc=%0d corr=%b lat=%0d, need data=%0d loc=%0d corr=%b lat=%0d",
                     obs.data, obs.loc, obs.corr, lat, exp.data, exp.loc, exp.corr, LAT);
        end
        release_word();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
